// File: rtl/pcm_sample_feeder_if.sv
// Three-wire serial host link (chip select, clock, data) into the PCM sample feeder.
// The host drives all three lines; the feeder only observes them.
interface pcm_sample_feeder_if;
  logic cs_n;
  logic sclk;
  logic mosi;

  modport master (output cs_n, output sclk, output mosi);
  modport slave  (input  cs_n, input  sclk, input  mosi);
endinterface

// File: rtl/pcm_sample_feeder.sv
// Serial PCM byte receiver feeding a sample FIFO that is drained at a fixed
// rate onto a registered 8-bit bus for the DAC stage.
module pcm_sample_feeder #(
  parameter int SAMPLE_DIV = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  pcm_sample_feeder_if.slave          link,
  output logic [7:0]                  sample_out,
  output logic                        sample_strobe,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  logic          cs_n_p0, cs_n_p1;
  logic          sclk_p0, sclk_p1, sclk_p2;
  logic          mosi_p0, mosi_p1;
  logic          sclk_rise;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          byte_done;
  logic [TW-1:0] timer_q;
  logic          tick;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q, level_nxt;
  logic          fifo_empty, fifo_full;
  logic          push_req, push, pop;

  // Stage p0/p1: two-flop synchronizers; p2 delays sclk for edge detection.
  // These keep running while ena is low, so sclk edges seen then are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_n_p0 <= 1'b1;
      cs_n_p1 <= 1'b1;
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
    end else begin
      cs_n_p0 <= link.cs_n;
      cs_n_p1 <= cs_n_p0;
      sclk_p0 <= link.sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
    end
  end

  always_ff @(posedge clk) begin
    mosi_p0 <= link.mosi;
    mosi_p1 <= mosi_p0;
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;

  // Receiver: byte_done is registered, so the FIFO write lands one cycle
  // after the eighth edge is detected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= 3'd0;
      byte_done <= 1'b0;
    end else if (ena) begin
      byte_done <= 1'b0;
      if (cs_n_p1) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        bit_cnt   <= bit_cnt + 3'd1;
        byte_done <= (bit_cnt == 3'd7);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ena && !cs_n_p1 && sclk_rise) shift_q <= {shift_q[6:0], mosi_p1};
  end

  // Sample timer
  assign tick = ena && (timer_q == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q       <= '0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= tick;
      if (ena) timer_q <= tick ? '0 : timer_q + TW'(1);
    end
  end

  // FIFO: a pop on a full FIFO frees the slot the simultaneous write reuses.
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LEVEL_FULL);
  assign push_req   = ena && byte_done;
  assign pop        = tick && !fifo_empty;
  assign push       = push_req && (!fifo_full || pop);

  always_comb begin
    level_nxt = level_q;
    if (push && !pop)      level_nxt = level_q + LW'(1);
    else if (pop && !push) level_nxt = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      sample_out <= 8'h80;
    end else begin
      level_q <= level_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        sample_out <= mem[rd_ptr];
      end
      if (push_req && !push) overflow <= 1'b1;
      if (tick && fifo_empty) underflow <= 1'b1;
    end
  end

  assign fifo_level = level_q;
endmodule

// File: tb/tb_pcm_sample_feeder.sv
// Directed bench for pcm_sample_feeder: serial byte reception, FIFO
// occupancy, fixed-rate playback, overflow/underflow and enable freeze.
module tb_pcm_sample_feeder;
  localparam int SDIV  = 1024;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] sample_out;
  logic       sample_strobe;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       underflow;

  int cyc = 0;
  int r0 = 0;
  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  pcm_sample_feeder_if link ();

  pcm_sample_feeder #(.SAMPLE_DIV(SDIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .link          (link),
    .sample_out    (sample_out),
    .sample_strobe (sample_strobe),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sample_strobe === 1'b1) strobe_cnt++;

  task automatic tick_clk();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick_clk();
  endtask

  task automatic run_until(input int c);
    while (cyc < c) tick_clk();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ena       = 1'b1;
    link.cs_n = 1'b1;
    link.sclk = 1'b0;
    link.mosi = 1'b0;
    run(3);
    rst_n = 1'b1;
    r0    = cyc;
  endtask

  // sclk = clk/4; the 8th rise is driven 30 cycles after the call starts.
  task automatic send_bits(input logic [7:0] b, input int nbits);
    link.cs_n = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      link.sclk = 1'b0;
      link.mosi = b[i];
      run(2);
      link.sclk = 1'b1;
      run(2);
    end
    link.sclk = 1'b0;
  endtask

  task automatic end_frame();
    link.cs_n = 1'b1;
    run(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
    end_frame();
  endtask

  initial begin
    int bad_strobe;
    int bad_out;
    int s0;
    logic exp_strobe;
    logic [7:0] seq [3];
    seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h56;

    // Reset and idle
    do_reset();
    chk("rst_sample_out", 32'(sample_out), 32'h80);
    chk("rst_strobe", 32'(sample_strobe), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_underflow", 32'(underflow), 32'h0);
    bad_strobe = 0;
    bad_out = 0;
    while (cyc < r0 + 3 * SDIV + 2) begin
      tick_clk();
      exp_strobe = ((cyc - r0) % SDIV) == 0;
      if (sample_strobe !== exp_strobe) bad_strobe++;
      if (sample_out !== 8'h80 || fifo_level !== 5'd0) bad_out++;
      if (cyc == r0 + SDIV - 1) chk("idle_underflow_before", 32'(underflow), 32'h0);
      if (cyc == r0 + SDIV) chk("idle_underflow_after", 32'(underflow), 32'h1);
    end
    chk("idle_strobe_cycles_wrong", 32'(bad_strobe), 32'h0);
    chk("idle_outputs_changed", 32'(bad_out), 32'h0);

    // Three bytes, then playback and hold
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send_bits(seq[k], 8);
      run(1);
      chk("rx_level_pre", 32'(fifo_level), 32'(k));
      run(1);
      chk("rx_level_post", 32'(fifo_level), 32'(k + 1));
      end_frame();
    end
    for (int k = 1; k <= 3; k++) begin
      run_until(r0 + k * SDIV);
      chk("play_strobe", 32'(sample_strobe), 32'h1);
      chk("play_sample", 32'(sample_out), 32'(seq[k-1]));
      chk("play_level", 32'(fifo_level), 32'(3 - k));
    end
    chk("play_underflow_clear", 32'(underflow), 32'h0);
    run_until(r0 + 4 * SDIV);
    chk("hold_sample", 32'(sample_out), 32'h56);
    chk("hold_underflow", 32'(underflow), 32'h1);

    // Overflow: 17 bytes before the first tick
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i));
      if (i == 15) chk("ovf_not_yet", 32'(overflow), 32'h0);
    end
    chk("ovf_level", 32'(fifo_level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'h1);
    for (int k = 1; k <= 16; k++) begin
      run_until(r0 + k * SDIV);
      chk("ovf_play", 32'(sample_out), 32'(k - 1));
    end
    chk("ovf_drain_underflow", 32'(underflow), 32'h0);
    run_until(r0 + 17 * SDIV);
    chk("ovf_no_0x10", 32'(sample_out), 32'h0f);
    chk("ovf_final_underflow", 32'(underflow), 32'h1);

    // Partial byte discarded
    do_reset();
    send_bits(8'hff, 5);
    end_frame();
    send_byte(8'ha5);
    chk("partial_level", 32'(fifo_level), 32'h1);
    run_until(r0 + SDIV);
    chk("partial_sample", 32'(sample_out), 32'ha5);

    // Write coincides with tick, FIFO full
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
    chk("full_pre_level", 32'(fifo_level), 32'd16);
    run_until(r0 + SDIV - 34);
    send_bits(8'h99, 8);
    run(2);
    chk("full_tick_strobe", 32'(sample_strobe), 32'h1);
    chk("full_tick_level", 32'(fifo_level), 32'd16);
    chk("full_tick_overflow", 32'(overflow), 32'h0);
    chk("full_tick_sample", 32'(sample_out), 32'h20);
    end_frame();

    // Write coincides with tick, FIFO empty
    do_reset();
    run_until(r0 + SDIV - 34);
    send_bits(8'h77, 8);
    run(2);
    chk("empty_tick_strobe", 32'(sample_strobe), 32'h1);
    chk("empty_tick_underflow", 32'(underflow), 32'h1);
    chk("empty_tick_sample", 32'(sample_out), 32'h80);
    chk("empty_tick_level", 32'(fifo_level), 32'h1);
    end_frame();
    run_until(r0 + 2 * SDIV);
    chk("empty_next_sample", 32'(sample_out), 32'h77);

    // ena low for 1000 cycles mid-period; a byte sent meanwhile is lost
    do_reset();
    send_byte(8'h3c);
    run_until(r0 + 500);
    ena = 1'b0;
    s0 = strobe_cnt;
    send_byte(8'hee);
    run_until(r0 + 1500);
    chk("ena_no_strobe", 32'(strobe_cnt - s0), 32'h0);
    chk("ena_level_held", 32'(fifo_level), 32'h1);
    chk("ena_sample_held", 32'(sample_out), 32'h80);
    ena = 1'b1;
    run_until(r0 + 2023);
    chk("ena_strobe_not_early", 32'(sample_strobe), 32'h0);
    run(1);
    chk("ena_strobe_resumed", 32'(sample_strobe), 32'h1);
    chk("ena_sample", 32'(sample_out), 32'h3c);
    chk("ena_lost_byte", 32'(fifo_level), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pcm_sample_feeder.md
# pcm_sample_feeder

Upstream audio source for the PWM / sigma-delta DAC stage. Receives 8-bit unsigned PCM bytes over a 3-wire serial link (cs_n, sclk, mosi) and buffers them in a small FIFO. It presents one sample per sample period on a registered 8-bit bus. That bus drives the DAC duty input directly, decoupling bursty host writes from the fixed playback rate.

## Interface

- SAMPLE_DIV, 256: clk cycles per sample period; 256 matches one 8-bit PWM period; legal range 4..65536.
- FIFO_DEPTH, 16: sample FIFO entries; power of two, 2..256.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  global enable; low freezes all state except the input synchronizers.
- cs_n  in  1  serial chip select, active-low, asynchronous to clk.
- sclk  in  1  serial clock, asynchronous; mosi is sampled on its rising edge; max frequency clk/4.
- mosi  in  1  serial data, MSB first.
- sample_out  out  8  current sample to the DAC, registered.
- sample_strobe  out  1  one-cycle pulse each time a sample period elapses.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- underflow  out  1  sticky: a sample period elapsed with the FIFO empty.

## Operation

- Synchronizers: cs_n, sclk and mosi each pass through 2 flops. An sclk rising edge is detected by comparing the synchronized value with a third delayed flop.
- Receiver: a 3-bit bit counter and an 8-bit shift register.
  - While synchronized cs_n is low, each detected sclk rise shifts mosi into the shift register LSB, moving earlier bits toward the MSB.
  - On the 8th bit, a byte-complete pulse fires and the bit counter wraps to 0.
  - Synchronized cs_n high clears the bit counter. A partial byte is discarded without a write.
- FIFO: circular buffer with read/write pointers of FIFO_DEPTH entries and a level counter.
  - Write on byte-complete if not full; else drop the byte and set overflow.
- Sample timer: counts 0..SAMPLE_DIV-1 and wraps. A tick fires when the count equals SAMPLE_DIV-1.
- On each tick:
  - sample_strobe pulses.
  - If the FIFO is non-empty, pop the head into sample_out.
  - If empty, sample_out holds its previous value and underflow is set.
- Simultaneous write and pop:
  - Both are performed.
  - When full: the pop frees a slot, the write is accepted, no overflow, and level stays FIFO_DEPTH.
  - When empty: the pop sees empty, so underflow is set and sample_out holds. The write is stored and level becomes 1.
- ena low:
  - Timer, receiver, FIFO and flags hold.
  - sclk edges arriving while ena is low are lost.
  - sample_strobe is 0.
- Sticky flags clear only on reset.

## Timing

- Reset values:
  - sample_out = 8'h80 (midscale silence).
  - sample_strobe = 0, fifo_level = 0, overflow = 0, underflow = 0.
  - Timer = 0, bit counter = 0, pointers = 0.
- Reset mid-byte or mid-period discards all buffered data and restarts the timer from 0.
- Receive latency:
  - The byte-complete pulse occurs in the cycle after the 8th sclk rise is detected.
  - fifo_level increments at the end of that cycle.
  - Total from pin edge to level change is at most 4 clk cycles.
- Tick timing:
  - The first tick is asserted in the SAMPLE_DIV-th enabled cycle after reset release.
  - sample_out and sample_strobe update at the clock edge ending the tick cycle, so both are visible the following cycle.
  - The strobe is high for exactly 1 cycle.
  - Ticks are exactly SAMPLE_DIV enabled cycles apart.
- fifo_level reflects pushes and pops registered at the same edge as sample_out.
- Overflow and underflow set at the edge ending the offending cycle.

## Test plan

- Reset then idle, SAMPLE_DIV=256 -> sample_out=0x80 throughout. Strobe first at cycle 256 and every 256 after. underflow=1 after the first strobe. fifo_level=0.
- Send bytes 0x12, 0x34, 0x56 (sclk=clk/8) -> fifo_level steps 1, 2, 3 within 4 clk of each 8th edge. Successive strobes yield sample_out 0x12, 0x34, 0x56, then hold 0x56 with underflow set.
- Send 17 bytes 0x00..0x10 with no tick in between (FIFO_DEPTH=16) -> level saturates at 16 and overflow=1. Playback yields 0x00..0x0F; 0x10 is absent.
- Raise cs_n after 5 bits, then send full byte 0xA5 -> only 0xA5 is stored, level=1.
- Complete a byte on the same cycle as a tick, with the FIFO full and again with it empty -> full: level stays 16, no overflow. Empty: underflow=1, sample_out held, level=1.
- Hold ena low for 1000 cycles mid-period, then high -> no strobe while low. The next strobe comes after the remaining count resumes, with outputs unchanged meanwhile.
